// File: rtl/lrelu_pkg.sv
// rtl/lrelu_pkg.sv - shared encodings and constants for the LReLU engine and its input scheduler
package lrelu_pkg;

    typedef enum logic [1:0] {
        CFG_HEAD = 2'd0,
        CFG_BODY = 2'd1,
        DATA     = 2'd2
    } sched_state_t;

    localparam int CONFIG_BEATS_3X3 = 21;
    localparam int CONFIG_BEATS_1X1 = 13;

    // tuser bit positions understood by the engine
    localparam int I_IS_1X1 = 5;

endpackage

// File: rtl/axis_lrelu_input_sched.sv
// rtl/axis_lrelu_input_sched.sv - merges config and data streams onto the LReLU engine input
module axis_lrelu_input_sched
    import lrelu_pkg::*;
#(
    parameter int WORD_WIDTH_IN    = 32,
    parameter int UNITS            = 8,
    parameter int GROUPS           = 2,
    parameter int COPIES           = 2,
    parameter int MEMBERS          = 2,
    parameter int TUSER_WIDTH      = 8,
    parameter int I_IS_1X1         = lrelu_pkg::I_IS_1X1,
    parameter int CONFIG_BEATS_3X3 = lrelu_pkg::CONFIG_BEATS_3X3,
    parameter int CONFIG_BEATS_1X1 = lrelu_pkg::CONFIG_BEATS_1X1,
    parameter int ITER_BITS        = 16,
    localparam int DATA_W          = MEMBERS * COPIES * GROUPS * UNITS * WORD_WIDTH_IN
) (
    input  logic                   aclk,
    input  logic                   areset,

    input  logic                   s_cfg_tvalid,
    output logic                   s_cfg_tready,
    input  logic [DATA_W-1:0]      s_cfg_tdata,
    input  logic                   s_cfg_is_1x1,
    input  logic                   s_cfg_tlast,

    input  logic                   s_dat_tvalid,
    output logic                   s_dat_tready,
    input  logic [DATA_W-1:0]      s_dat_tdata,
    input  logic [TUSER_WIDTH-1:0] s_dat_tuser,
    input  logic                   s_dat_tlast,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,

    output logic [ITER_BITS-1:0]   iter_count,
    output logic                   cfg_err,
    output logic                   busy
);

    localparam int MAX_BEATS = (CONFIG_BEATS_3X3 > CONFIG_BEATS_1X1) ? CONFIG_BEATS_3X3 : CONFIG_BEATS_1X1;
    localparam int REM_W     = $clog2(MAX_BEATS);

    sched_state_t           state_q, state_d, eff_state;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic                   is_1x1_q, is_1x1_d;
    logic [ITER_BITS-1:0]   iter_q, iter_d;
    logic                   err_q, err_d;
    logic                   cfg_sel;
    logic                   cfg_hs;
    logic                   dat_hs;

    // While reset is held the outputs already behave as in CFG_HEAD, even before the register clears
    always_comb begin
        eff_state = areset ? CFG_HEAD : state_q;
    end

    assign cfg_sel = (eff_state != DATA);
    assign cfg_hs  = s_cfg_tvalid & s_cfg_tready;
    assign dat_hs  = s_dat_tvalid & s_dat_tready;

    // Source mux and handshake steering; purely combinational so there is no latency added
    always_comb begin
        s_cfg_tready  = 1'b0;
        s_dat_tready  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        if (cfg_sel) begin
            s_cfg_tready           = m_axis_tready;
            m_axis_tvalid          = s_cfg_tvalid;
            m_axis_tdata           = s_cfg_tdata;
            m_axis_tuser[I_IS_1X1] = (eff_state == CFG_BODY) ? is_1x1_q : s_cfg_is_1x1;
        end else begin
            s_dat_tready  = m_axis_tready;
            m_axis_tvalid = s_dat_tvalid;
            m_axis_tdata  = s_dat_tdata;
            m_axis_tuser  = s_dat_tuser;
            m_axis_tlast  = s_dat_tlast;
        end
    end

    // Next-state: beat counter alone drives transitions, config tlast only feeds the framing check
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        is_1x1_d = is_1x1_q;
        iter_d   = iter_q;
        err_d    = err_q;
        case (state_q)
            CFG_HEAD: begin
                if (cfg_hs) begin
                    is_1x1_d = s_cfg_is_1x1;
                    rem_d    = s_cfg_is_1x1 ? REM_W'(CONFIG_BEATS_1X1 - 2) : REM_W'(CONFIG_BEATS_3X3 - 2);
                    state_d  = CFG_BODY;
                    if (s_cfg_tlast) err_d = 1'b1;
                end
            end
            CFG_BODY: begin
                if (cfg_hs) begin
                    if (rem_q == '0) begin
                        state_d = DATA;
                        if (!s_cfg_tlast) err_d = 1'b1;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                        if (s_cfg_tlast) err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dat_hs && s_dat_tlast) begin
                    iter_d  = iter_q + ITER_BITS'(1);
                    state_d = CFG_HEAD;
                end
            end
            default: state_d = CFG_HEAD;
        endcase
    end

    // State and status registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= CFG_HEAD;
            rem_q    <= '0;
            is_1x1_q <= 1'b0;
            iter_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            is_1x1_q <= is_1x1_d;
            iter_q   <= iter_d;
            err_q    <= err_d;
        end
    end

    assign iter_count = areset ? '0 : iter_q;
    assign cfg_err    = areset ? 1'b0 : err_q;
    assign busy       = (eff_state != CFG_HEAD);

endmodule

// File: tb/tb_axis_lrelu_input_sched.sv
// tb/tb_axis_lrelu_input_sched.sv - randomized self-checking bench for axis_lrelu_input_sched
module tb_axis_lrelu_input_sched;

    localparam int W = 8, U = 1, G = 2, C = 2, M = 2;
    localparam int DW = M * C * G * U * W;
    localparam int TU = 8;
    localparam int IB = 2;
    localparam int IS_BIT = 5;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic          s_cfg_tvalid, s_cfg_tready, s_cfg_is_1x1, s_cfg_tlast;
    logic [DW-1:0] s_cfg_tdata;
    logic          s_dat_tvalid, s_dat_tready, s_dat_tlast;
    logic [DW-1:0] s_dat_tdata;
    logic [TU-1:0] s_dat_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [TU-1:0] m_axis_tuser;
    logic [IB-1:0] iter_count;
    logic          cfg_err, busy;

    axis_lrelu_input_sched #(
        .WORD_WIDTH_IN(W), .UNITS(U), .GROUPS(G), .COPIES(C), .MEMBERS(M),
        .TUSER_WIDTH(TU), .I_IS_1X1(IS_BIT), .CONFIG_BEATS_3X3(21),
        .CONFIG_BEATS_1X1(13), .ITER_BITS(IB)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready), .s_cfg_tdata(s_cfg_tdata),
        .s_cfg_is_1x1(s_cfg_is_1x1), .s_cfg_tlast(s_cfg_tlast),
        .s_dat_tvalid(s_dat_tvalid), .s_dat_tready(s_dat_tready), .s_dat_tdata(s_dat_tdata),
        .s_dat_tuser(s_dat_tuser), .s_dat_tlast(s_dat_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .iter_count(iter_count), .cfg_err(cfg_err), .busy(busy)
    );

    typedef struct { logic [DW-1:0] data; logic is1x1; logic last; } cfg_beat_t;
    typedef struct { logic [DW-1:0] data; logic [TU-1:0] user; logic last; } dat_beat_t;
    typedef struct {
        logic [DW-1:0] data; logic [TU-1:0] user; logic last;
        logic is_cfg; logic first; logic final_cfg;
    } exp_beat_t;

    cfg_beat_t cfg_q[$];
    dat_beat_t dat_q[$];
    exp_beat_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Stream-level model: output is each config block (tuser flag only, tlast 0) followed by its data block
    task automatic add_iter(input bit is1x1, input int ndata, input int bad_pos);
        int n;
        cfg_beat_t cb;
        dat_beat_t db;
        exp_beat_t eb;
        n = is1x1 ? 13 : 21;
        for (int i = 1; i <= n; i++) begin
            cb.data  = {$urandom, $urandom};
            cb.is1x1 = (i == 1) ? is1x1 : 1'($urandom_range(1));
            cb.last  = (bad_pos > 0) ? (i == bad_pos) : (i == n);
            cfg_q.push_back(cb);
            eb.data = cb.data; eb.user = is1x1 ? (TU'(1) << IS_BIT) : '0; eb.last = 1'b0;
            eb.is_cfg = 1'b1; eb.first = (i == 1); eb.final_cfg = (i == n);
            exp_q.push_back(eb);
        end
        for (int j = 1; j <= ndata; j++) begin
            db.data = {$urandom, $urandom};
            db.user = TU'($urandom);
            db.last = (j == ndata);
            dat_q.push_back(db);
            eb.data = db.data; eb.user = db.user; eb.last = db.last;
            eb.is_cfg = 1'b0; eb.first = 1'b0; eb.final_cfg = 1'b0;
            exp_q.push_back(eb);
        end
    endtask

    int  iter_exp = 0;
    bit  err_exp = 1'b0;

    // Compare process: every cycle, DUT outputs against the stream model
    always @(negedge aclk) begin
        exp_beat_t e;
        if (areset) begin
            chk("rst_dat_tready", 64'(s_dat_tready), 64'd0);
            chk("rst_cfg_tready", 64'(s_cfg_tready), 64'(m_axis_tready));
            chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(s_cfg_tvalid));
            chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_iter", 64'(iter_count), 64'd0);
            chk("rst_err", 64'(cfg_err), 64'd0);
            iter_exp = 0;
            err_exp  = 1'b0;
        end else begin
            chk("iter_count", 64'(iter_count), 64'(iter_exp));
            chk("cfg_err", 64'(cfg_err), 64'(err_exp));
            if (exp_q.size() == 0) begin
                chk("idle_busy", 64'(busy), 64'd0);
                chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
            end else begin
                e = exp_q[0];
                chk("busy", 64'(busy), 64'(!(e.is_cfg && e.first)));
                chk("m_tvalid", 64'(m_axis_tvalid), 64'(e.is_cfg ? s_cfg_tvalid : s_dat_tvalid));
                chk("cfg_tready", 64'(s_cfg_tready), 64'(e.is_cfg && m_axis_tready));
                chk("dat_tready", 64'(s_dat_tready), 64'(!e.is_cfg && m_axis_tready));
                if (m_axis_tvalid) begin
                    chk("m_tdata", m_axis_tdata, e.data);
                    chk("m_tuser", 64'(m_axis_tuser), 64'(e.user));
                    chk("m_tlast", 64'(m_axis_tlast), 64'(e.last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (e.is_cfg && (s_cfg_tlast !== e.final_cfg)) err_exp = 1'b1;
                    if (!e.is_cfg && e.last) iter_exp = (iter_exp + 1) % (1 << IB);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    int vprob = 100, rprob = 100;
    bit ready_toggle = 1'b0;
    bit cfg_v = 1'b0, dat_v = 1'b0, hs_c = 1'b0, hs_d = 1'b0;
    int step_no = 0, first_dat = 0, dat_cnt = 0;

    task automatic drive();
        if (!(cfg_v && !hs_c)) cfg_v = (cfg_q.size() > 0) && ($urandom_range(99) < vprob);
        if (!(dat_v && !hs_d)) dat_v = (dat_q.size() > 0) && ($urandom_range(99) < vprob);
        s_cfg_tvalid = cfg_v;
        if (cfg_q.size() > 0) begin
            s_cfg_tdata = cfg_q[0].data; s_cfg_is_1x1 = cfg_q[0].is1x1; s_cfg_tlast = cfg_q[0].last;
        end else begin
            s_cfg_tdata = '0; s_cfg_is_1x1 = 1'b0; s_cfg_tlast = 1'b0;
        end
        s_dat_tvalid = dat_v;
        if (dat_q.size() > 0) begin
            s_dat_tdata = dat_q[0].data; s_dat_tuser = dat_q[0].user; s_dat_tlast = dat_q[0].last;
        end else begin
            s_dat_tdata = '0; s_dat_tuser = '0; s_dat_tlast = 1'b0;
        end
        m_axis_tready = ready_toggle ? ~m_axis_tready : ($urandom_range(99) < rprob);
    endtask

    task automatic step();
        @(negedge aclk);
        hs_c = s_cfg_tvalid && s_cfg_tready;
        hs_d = s_dat_tvalid && s_dat_tready;
        @(posedge aclk);
        #1;
        if (hs_c) void'(cfg_q.pop_front());
        if (hs_d) begin
            void'(dat_q.pop_front());
            dat_cnt++;
        end
        step_no++;
        if (hs_d && first_dat == 0) first_dat = step_no;
        drive();
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int wrap_exp[5] = '{1, 2, 3, 0, 1};
        s_cfg_tvalid = 0; s_cfg_tdata = '0; s_cfg_is_1x1 = 0; s_cfg_tlast = 0;
        s_dat_tvalid = 0; s_dat_tdata = '0; s_dat_tuser = '0; s_dat_tlast = 0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;

        // 3x3 iteration, all ready: 26 back-to-back beats
        add_iter(1'b0, 5, 0);
        hs_c = 0; hs_d = 0;
        drive();
        run(200, n);
        chk("t1_cycles", 64'(n), 64'd26);
        chk("t1_iter", 64'(iter_count), 64'd1);
        chk("t1_err", 64'(cfg_err), 64'd0);

        // 1x1 iteration: data accepted exactly on cycle 14
        step_no = 0; first_dat = 0;
        add_iter(1'b1, 3, 0);
        drive();
        run(200, n);
        chk("t2_dat_cycle", 64'(first_dat), 64'd14);
        chk("t2_iter", 64'(iter_count), 64'd2);

        // Contention and toggling backpressure over several random iterations
        vprob = 60; ready_toggle = 1'b1;
        for (int k = 0; k < 6; k++) add_iter(1'($urandom_range(1)), $urandom_range(1, 6), 0);
        drive();
        run(3000, n);
        chk("t3_iter", 64'(iter_count), 64'd0);
        vprob = 100; ready_toggle = 1'b0; rprob = 100;

        // Framing error: early tlast on beat 20, stays sticky
        add_iter(1'b0, 2, 20);
        drive();
        run(200, n);
        chk("t4_err", 64'(cfg_err), 64'd1);
        add_iter(1'b1, 1, 0);
        drive();
        run(200, n);
        chk("t4_err_sticky", 64'(cfg_err), 64'd1);
        chk("t4_iter", 64'(iter_count), 64'd2);

        // Reset during data beat 3
        add_iter(1'b0, 6, 0);
        dat_cnt = 0; n = 0;
        drive();
        while (dat_cnt < 2 && n < 200) begin
            step();
            n++;
        end
        chk("t5_reach", 64'(dat_cnt), 64'd2);
        areset = 1'b1;
        step();
        areset = 1'b0;
        cfg_q.delete(); dat_q.delete(); exp_q.delete();
        cfg_v = 0; dat_v = 0; hs_c = 0; hs_d = 0;
        drive();
        step();
        chk("t5_iter", 64'(iter_count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_dat_tready", 64'(s_dat_tready), 64'd0);

        // Minimal iterations wrap the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            add_iter(1'b1, 1, 0);
            drive();
            run(200, n);
            chk("t6_wrap", 64'(iter_count), 64'(wrap_exp[k]));
        end
        chk("t6_err", 64'(cfg_err), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
